// File: rtl/audio_channel_ctrl.sv
// Front-panel channel/volume sequencer: debounced buttons, click-free ramps.
// Optional mute button/output enabled by defining AUDIO_CHANNEL_CTRL_MUTE_EN.

module audio_channel_ctrl_db #(
    parameter int unsigned CYCLES = 50000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Btn,
    output logic Press
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

    logic          s1;
    logic          s2;
    logic          lvl;
    logic [CW-1:0] cnt;

    // Synchronise, accept a level after CYCLES equal samples, pulse on rise
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            cnt   <= '0;
            Press <= 1'b0;
        end else begin
            s1    <= Btn;
            s2    <= s1;
            Press <= 1'b0;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                lvl   <= s2;
                cnt   <= '0;
                Press <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

module audio_channel_ctrl #(
    parameter int unsigned NUM_CHANNELS    = 6,
    parameter int unsigned VOL_STEP        = 32,
    parameter int unsigned VOL_INIT        = 512,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned RAMP_DIV        = 1024
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Btn_Next,
    input  logic       Btn_VolUp,
    input  logic       Btn_VolDn,
`ifdef AUDIO_CHANNEL_CTRL_MUTE_EN
    input  logic       Btn_Mute,
    output logic       Muted,
`endif
    output logic [3:0] Channel,
    output logic [9:0] Volume,
    output logic       Busy
);

    localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    typedef enum logic [1:0] {
        RUN,
        FADE_OUT,
        SWITCH,
        FADE_IN
    } state_t;

    state_t        state;
    logic          next_p;
    logic          up_p;
    logic          dn_p;
    logic [RW-1:0] rcnt;
    logic          tick;
    logic [9:0]    tgt_vol;
    logic [9:0]    eff;
    logic [10:0]   up_sum;
    logic [9:0]    vol_toward;

    audio_channel_ctrl_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .Clk(Clk), .Reset(Reset), .Btn(Btn_Next), .Press(next_p)
    );
    audio_channel_ctrl_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .Clk(Clk), .Reset(Reset), .Btn(Btn_VolUp), .Press(up_p)
    );
    audio_channel_ctrl_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .Clk(Clk), .Reset(Reset), .Btn(Btn_VolDn), .Press(dn_p)
    );

`ifdef AUDIO_CHANNEL_CTRL_MUTE_EN
    logic mute_p;

    audio_channel_ctrl_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mute (
        .Clk(Clk), .Reset(Reset), .Btn(Btn_Mute), .Press(mute_p)
    );

    // Each mute press flips the mute state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) Muted <= 1'b0;
        else if (mute_p) Muted <= ~Muted;
    end

    assign eff = Muted ? 10'd0 : tgt_vol;
`else
    assign eff = tgt_vol;
`endif

    assign tick = (rcnt == RW'(RAMP_DIV - 1));
    assign up_sum = {1'b0, tgt_vol} + 11'(VOL_STEP);
    assign vol_toward = (Volume < eff) ? Volume + 10'd1 :
                        (Volume > eff) ? Volume - 10'd1 : Volume;

    // Free-running ramp divider
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) rcnt <= '0;
        else if (tick) rcnt <= '0;
        else rcnt <= rcnt + 1'b1;
    end

    // Saturating target volume; simultaneous up and down cancel
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tgt_vol <= 10'(VOL_INIT);
        end else if (up_p && !dn_p) begin
            tgt_vol <= (up_sum > 11'd1023) ? 10'd1023 : up_sum[9:0];
        end else if (dn_p && !up_p) begin
            tgt_vol <= ({1'b0, tgt_vol} < 11'(VOL_STEP)) ?
                       10'd0 : tgt_vol - 10'(VOL_STEP);
        end
    end

    // Sequencer: fade out, switch channel at silence, fade back in
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= FADE_IN;
            Busy    <= 1'b1;
            Channel <= 4'd0;
            Volume  <= 10'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (next_p) begin
                        state <= FADE_OUT;
                        Busy  <= 1'b1;
                    end else if (tick) begin
                        Volume <= vol_toward;
                    end
                end
                FADE_OUT: begin
                    if (Volume == 10'd0) state <= SWITCH;
                    else if (tick) Volume <= Volume - 10'd1;
                end
                SWITCH: begin
                    Channel <= (Channel == 4'(NUM_CHANNELS - 1)) ?
                               4'd0 : Channel + 4'd1;
                    state   <= FADE_IN;
                end
                FADE_IN: begin
                    if (next_p) begin
                        state <= FADE_OUT;
                    end else if (Volume == eff) begin
                        state <= RUN;
                        Busy  <= 1'b0;
                    end else if (tick) begin
                        Volume <= vol_toward;
                    end
                end
                default: begin
                    state <= FADE_IN;
                    Busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
